// File: rtl/pe_credit_node_if.sv
// Purpose: bundles the injection, send, credit and ejection signals of one PE.
// Latency: none, wiring only.
// Backpressure: src_ready from the PE to the source; credits ci/co towards the router.
interface pe_credit_node_if #(
    parameter int FLIT_W = 20
);
    logic [FLIT_W-1:0] src_data;
    logic              src_valid;
    logic              src_ready;
    logic [FLIT_W-1:0] dataout;
    logic              out_valid;
    logic              ci;
    logic [FLIT_W-1:0] datain;
    logic              in_valid;
    logic              co;
    logic [FLIT_W-1:0] snk_data;
    logic              snk_valid;
    logic              credit_err;

    // PE side
    modport master (
        input  src_data, src_valid, ci, datain, in_valid,
        output src_ready, dataout, out_valid, co, snk_data, snk_valid, credit_err
    );

    // Source / router / sink side
    modport slave (
        output src_data, src_valid, ci, datain, in_valid,
        input  src_ready, dataout, out_valid, co, snk_data, snk_valid, credit_err
    );
endinterface

// File: rtl/pe_credit_node.sv
// Purpose: NoC PE, injection FIFO gated by downstream credits plus registered ejection with credit return.
// Latency: push to out_valid 2 edges (no bypass); in_valid to snk_valid/co 1 edge.
// Backpressure: src_ready = !full; sends stall at zero credits. Optional PE_STATS_EN adds tx/rx counters.
module pe_credit_node #(
    parameter int FLIT_W  = 20,
    parameter int CREDITS = 4,
    parameter int DEPTH   = 8
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    pe_credit_node_if.master bus
`ifdef PE_STATS_EN
    ,
    output logic [31:0] tx_count_o,
    output logic [31:0] rx_count_o
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(CREDITS + 1);
    localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);
    localparam logic [CW-1:0] CRED_ONE = CW'(1);
    localparam logic [AW:0]   PTR_ONE  = (AW + 1)'(1);

    logic [FLIT_W-1:0] mem_q [DEPTH];
    logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     credit_cnt_q, credit_cnt_d;
    logic [FLIT_W-1:0] dataout_q, dataout_d, snk_data_q, snk_data_d;
    logic              out_valid_q, out_valid_d;
    logic              co_q, co_d, snk_valid_q, snk_valid_d;
    logic              credit_err_q, credit_err_d;
    logic              empty, full, push, send;

    // Wrap bit distinguishes full from empty when the index bits match
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push  = bus.src_valid && !full;
    assign send  = !empty && (credit_cnt_q != '0);

    assign bus.src_ready  = !full;
    assign bus.dataout    = dataout_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.co         = co_q;
    assign bus.snk_data   = snk_data_q;
    assign bus.snk_valid  = snk_valid_q;
    assign bus.credit_err = credit_err_q;

    // Next state: FIFO pointers, send path, credit accounting, ejection path
    always_comb begin
        wr_ptr_d     = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d     = send ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        out_valid_d  = send;
        dataout_d    = send ? mem_q[rd_ptr_q[AW-1:0]] : dataout_q;
        credit_cnt_d = credit_cnt_q;
        credit_err_d = credit_err_q;
        if (send && !bus.ci) begin
            credit_cnt_d = credit_cnt_q - CRED_ONE;
        end else if (bus.ci && !send) begin
            // A credit beyond the downstream depth means the router miscounted
            if (credit_cnt_q == CRED_MAX) begin
                credit_err_d = 1'b1;
            end else begin
                credit_cnt_d = credit_cnt_q + CRED_ONE;
            end
        end
        snk_valid_d = bus.in_valid;
        co_d        = bus.in_valid;
        snk_data_d  = bus.in_valid ? bus.datain : snk_data_q;
    end

    // FIFO storage needs no reset; the pointers define its contents
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= bus.src_data;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            credit_cnt_q <= CRED_MAX;
            out_valid_q  <= 1'b0;
            dataout_q    <= '0;
            co_q         <= 1'b0;
            snk_valid_q  <= 1'b0;
            snk_data_q   <= '0;
            credit_err_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            credit_cnt_q <= credit_cnt_d;
            out_valid_q  <= out_valid_d;
            dataout_q    <= dataout_d;
            co_q         <= co_d;
            snk_valid_q  <= snk_valid_d;
            snk_data_q   <= snk_data_d;
            credit_err_q <= credit_err_d;
        end
    end

`ifdef PE_STATS_EN
    logic [31:0] tx_count_q, tx_count_d, rx_count_q, rx_count_d;

    // Traffic counters, wrap naturally at 32 bits
    always_comb begin
        tx_count_d = tx_count_q + (out_valid_q  ? 32'd1 : 32'd0);
        rx_count_d = rx_count_q + (bus.in_valid ? 32'd1 : 32'd0);
    end

    // Counter registers
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            tx_count_q <= '0;
            rx_count_q <= '0;
        end else begin
            tx_count_q <= tx_count_d;
            rx_count_q <= rx_count_d;
        end
    end

    assign tx_count_o = tx_count_q;
    assign rx_count_o = rx_count_q;
`endif
endmodule

// File: tb/tb_pe_credit_node.sv
module tb_pe_credit_node;
    localparam int FLIT_W  = 20;
    localparam int CREDITS = 4;
    localparam int DEPTH   = 8;

    typedef struct {
        logic [FLIT_W-1:0] dat;
        int                cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pe_credit_node_if #(.FLIT_W(FLIT_W)) bus ();
`ifdef PE_STATS_EN
    logic [31:0] tx_count, rx_count;
`endif

    pe_credit_node #(.FLIT_W(FLIT_W), .CREDITS(CREDITS), .DEPTH(DEPTH)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus.master)
`ifdef PE_STATS_EN
        ,
        .tx_count_o (tx_count),
        .rx_count_o (rx_count)
`endif
    );

    // Reference model: flit queue, credit integer, scoreboards
    logic [FLIT_W-1:0] fq[$];
    int   cred = CREDITS;
    bit   err  = 0;
    int   txc = 0, rxc = 0;
    bit   last_send = 0;
    exp_t exp_tx[$];
    exp_t exp_rx[$];

    int n_chk = 0, n_fail = 0;
    int cyc = 0;

    task automatic chk(input string name, input longint act, input longint req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops scoreboards whenever the DUT presents a flit
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (bus.out_valid === 1'b1) begin
                if (exp_tx.size() == 0) begin
                    chk("unexpected_out_valid", 1, 0);
                end else begin
                    e = exp_tx.pop_front();
                    chk("dataout", bus.dataout, e.dat);
                    chk("dataout_cycle", cyc, e.cyc);
                end
            end else if (exp_tx.size() > 0 && exp_tx[0].cyc <= cyc) begin
                e = exp_tx.pop_front();
                chk("missing_out_valid", 0, 1);
            end
            if (bus.snk_valid === 1'b1) begin
                chk("co_with_snk_valid", bus.co, 1);
                if (exp_rx.size() == 0) begin
                    chk("unexpected_snk_valid", 1, 0);
                end else begin
                    e = exp_rx.pop_front();
                    chk("snk_data", bus.snk_data, e.dat);
                    chk("snk_cycle", cyc, e.cyc);
                end
            end else begin
                if (bus.co === 1'b1) chk("co_without_snk_valid", 1, 0);
                if (exp_rx.size() > 0 && exp_rx[0].cyc <= cyc) begin
                    e = exp_rx.pop_front();
                    chk("missing_snk_valid", 0, 1);
                end
            end
        end
    end

    // One clock of stimulus: check the state left by the last edge, then drive and model the next edge
    task automatic step(input bit rst, input bit sv, input logic [FLIT_W-1:0] sd,
                        input bit c, input bit iv, input logic [FLIT_W-1:0] di);
        bit snd, pu;
        int edge_n;
        exp_t e;
        @(posedge clk);
        #2;
        chk("src_ready", bus.src_ready, (fq.size() < DEPTH) ? 1 : 0);
        chk("credit_err", bus.credit_err, err);
        chk("credit_cnt", int'(dut.credit_cnt_q), cred);
`ifdef PE_STATS_EN
        chk("tx_count", tx_count, txc);
        chk("rx_count", rx_count, rxc);
`endif
        rst_n         = rst;
        bus.src_valid = sv;
        bus.src_data  = sd;
        bus.ci        = c;
        bus.in_valid  = iv;
        bus.datain    = di;
        edge_n = cyc + 1;
        if (!rst) begin
            fq.delete();
            cred = CREDITS;
            err = 0;
            txc = 0;
            rxc = 0;
            last_send = 0;
        end else begin
            snd = (fq.size() > 0) && (cred > 0);
            pu  = sv && (fq.size() < DEPTH);
            txc += last_send ? 1 : 0;
            last_send = snd;
            rxc += iv ? 1 : 0;
            if (snd) begin
                e.dat = fq.pop_front();
                e.cyc = edge_n;
                exp_tx.push_back(e);
            end
            if (snd && !c) cred--;
            else if (c && !snd) begin
                if (cred == CREDITS) err = 1;
                else cred++;
            end
            if (pu) fq.push_back(sd);
            if (iv) begin
                e.dat = di;
                e.cyc = edge_n;
                exp_rx.push_back(e);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, '0, 0, 0, '0);
    endtask

    task automatic push(input logic [FLIT_W-1:0] d);
        step(1, 1, d, 0, 0, '0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.src_valid = 0; bus.src_data = '0; bus.ci = 0;
        bus.in_valid = 0;  bus.datain = '0;
        repeat (2) @(posedge clk);

        // Reset state then three flits back to back, credits end at 1
        step(0, 0, '0, 0, 0, '0);
        push(20'h00001); push(20'h00002); push(20'h00003);
        idle(5);

        // Six flits with four credits, then two single credits
        step(0, 0, '0, 0, 0, '0);
        for (int i = 0; i < 6; i++) push(20'h00100 + 20'(i));
        idle(6);
        step(1, 0, '0, 1, 0, '0);
        idle(3);
        step(1, 0, '0, 1, 0, '0);
        idle(3);

        // No credits left: fill FIFO, then push and pop together with credits returning
        for (int i = 0; i < 8; i++) push(20'h00200 + 20'(i));
        step(1, 1, 20'h002FF, 0, 0, '0);
        for (int i = 0; i < 24; i++) step(1, 1, 20'h00300 + 20'(i), (i % 2) == 0, 0, '0);
        for (int i = 0; i < 20; i++) step(1, 0, '0, 1, 0, '0);
        idle(4);

        // Five consecutive ejected flits
        for (int i = 0; i < 5; i++) step(1, 0, '0, 0, 1, 20'hA0000 + 20'(i));
        idle(3);

        // Excess credit sets the sticky error; send and ci together at count 2
        step(0, 0, '0, 0, 0, '0);
        step(1, 0, '0, 1, 0, '0);
        idle(2);
        push(20'h00401); push(20'h00402);
        idle(3);
        push(20'h00403);
        step(1, 0, '0, 1, 0, '0);
        idle(3);

        // Reset mid-burst with flits still queued
        step(0, 0, '0, 0, 0, '0);
        for (int i = 0; i < 7; i++) step(1, 1, 20'h00500 + 20'(i), 0, 1, 20'h00600 + 20'(i));
        step(0, 0, '0, 1, 1, 20'h00777);
        idle(3);

        // Randomised traffic with occasional resets
        for (int i = 0; i < 800; i++)
            step($urandom_range(0, 149) != 0, $urandom_range(0, 1) == 1, 20'($urandom),
                 $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, 20'($urandom));
        for (int i = 0; i < 20; i++) step(1, 0, '0, 1, 0, '0);
        idle(4);

        chk("tx_scoreboard_empty", exp_tx.size(), 0);
        chk("rx_scoreboard_empty", exp_rx.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
